// File: rtl/dff_bank_arbiter_pkg.sv
// Shared types for the dff bank arbiter: opcodes and sequencer states.
package dff_bank_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_SET   = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_APPLY = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dff_bank_arbiter_if.sv
// Requester-side handshake bundle: request/opcode/data in, grant/ack/rdata out.
interface dff_bank_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    logic [NUM_REQ-1:0]       req;
    logic [2*NUM_REQ-1:0]     req_op;
    logic [WIDTH*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       ack;
    logic [WIDTH-1:0]         rdata;
    logic                     busy;

    modport master (
        output req, req_op, req_data,
        input  gnt, ack, rdata, busy
    );

    modport slave (
        input  req, req_op, req_data,
        output gnt, ack, rdata, busy
    );
endinterface

// File: rtl/dff_bank_arbiter_rr_picker.sv
// Combinational round-robin scan: first asserted req at or after rr_ptr.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      rr_ptr,
    output logic [IW-1:0]      win,
    output logic               found
);
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IW-1:0]        off;
    logic [IW:0]          sum;

    // Rotating a doubled copy puts rr_ptr at bit 0, so the lowest set bit wins.
    assign dbl = {req, req};
    assign rot = dbl[rr_ptr +: NUM_REQ];

    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                off   = IW'(k);
            end
        end
        sum = {1'b0, rr_ptr} + {1'b0, off};
        if (sum >= (IW+1)'(NUM_REQ)) begin
            sum = sum - (IW+1)'(NUM_REQ);
        end
        win = sum[IW-1:0];
    end
endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin sequencer sharing one dff bank among NUM_REQ requesters.
module dff_bank_arbiter
    import dff_bank_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic              clk,
    input  logic              reset,
    dff_bank_arbiter_if.slave rq,
    output logic [WIDTH-1:0]  bank_d,
    output logic              bank_en,
    output logic              bank_set,
    output logic              bank_rst,
    input  logic [WIDTH-1:0]  bank_q
);
    localparam int IW = idx_w(NUM_REQ);

    state_t               state;
    logic [IW-1:0]        rr_ptr;
    logic [IW-1:0]        win_q;
    logic [IW-1:0]        win;
    logic [IW-1:0]        nxt_ptr;
    logic                 found;
    op_e                  op_q;
    logic [WIDTH-1:0]     data_q;
    logic [WIDTH-1:0]     rdata_q;
    logic [NUM_REQ-1:0]   gnt_q;
    logic [NUM_REQ-1:0]   ack_q;
    logic [1:0]           op_arr  [NUM_REQ];
    logic [WIDTH-1:0]     dat_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign op_arr[i]  = rq.req_op[2*i +: 2];
        assign dat_arr[i] = rq.req_data[WIDTH*i +: WIDTH];
    end

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req    (rq.req),
        .rr_ptr (rr_ptr),
        .win    (win),
        .found  (found)
    );

    assign nxt_ptr = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;

    assign rq.gnt  = gnt_q;
    assign rq.ack  = ack_q;
    assign rq.busy = (state != ST_IDLE);
    // Bank update lands at the APPLY->DONE edge, so DONE shows q directly.
    assign rq.rdata = (state == ST_DONE) ? bank_q : rdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            win_q    <= '0;
            op_q     <= OP_READ;
            data_q   <= '0;
            rdata_q  <= '0;
            gnt_q    <= '0;
            ack_q    <= '0;
            bank_d   <= '0;
            bank_en  <= 1'b0;
            bank_set <= 1'b0;
            bank_rst <= 1'b0;
        end else begin
            gnt_q    <= '0;
            ack_q    <= '0;
            bank_d   <= '0;
            bank_en  <= 1'b0;
            bank_set <= 1'b0;
            bank_rst <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (found) begin
                        win_q  <= win;
                        op_q   <= op_e'(op_arr[win]);
                        data_q <= dat_arr[win];
                        gnt_q  <= NUM_REQ'(1) << win;
                        rr_ptr <= nxt_ptr;
                        state  <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    state <= ST_APPLY;
                    unique case (op_q)
                        OP_WRITE: begin
                            bank_en <= 1'b1;
                            bank_d  <= data_q;
                        end
                        OP_SET:   bank_set <= 1'b1;
                        OP_CLEAR: bank_rst <= 1'b1;
                        OP_READ:  ;
                    endcase
                end
                ST_APPLY: begin
                    ack_q <= NUM_REQ'(1) << win_q;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    rdata_q <= bank_q;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Scoreboard bench for dff_bank_arbiter with a dff-cell bank model.
module tb_dff_bank_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    typedef struct {
        int         idx;
        logic [7:0] rd;
    } ack_t;

    typedef struct {
        logic       en;
        logic       set;
        logic       rst;
        logic [7:0] d;
    } app_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] bank_d;
    logic         bank_en;
    logic         bank_set;
    logic         bank_rst;
    logic [W-1:0] bank_q = '0;

    int   checks = 0;
    int   fails  = 0;
    int   gntq[$];
    app_t appq[$];
    ack_t ackq[$];
    int   cyc = 0;
    int   idle_cnt = 0;
    int   last_idle = 0;
    int   last_gnt_cyc = -1;
    bit   apply_pend = 0;
    bit   chk_space = 0;

    dff_bank_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

    dff_bank_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .rq       (bus.slave),
        .bank_d   (bank_d),
        .bank_en  (bank_en),
        .bank_set (bank_set),
        .bank_rst (bank_rst),
        .bank_q   (bank_q)
    );

    always #5 clk = ~clk;

    // Shared-control dff bank: reset beats set beats enable.
    always @(posedge clk) begin
        if (bank_rst)      bank_q <= '0;
        else if (bank_set) bank_q <= '1;
        else if (bank_en)  bank_q <= bank_d;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_op(input int idx, input logic en, input logic set,
                             input logic rst, input logic [7:0] d,
                             input logic [7:0] rd, input bit has_ack);
        app_t a;
        ack_t k;
        a.en = en; a.set = set; a.rst = rst; a.d = d;
        k.idx = idx; k.rd = rd;
        gntq.push_back(idx);
        appq.push_back(a);
        if (has_ack) ackq.push_back(k);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            apply_pend = 0;
            idle_cnt   = 0;
        end else begin
            cyc++;
            if (!bus.busy) idle_cnt++;
            else begin
                if (idle_cnt != 0) last_idle = idle_cnt;
                idle_cnt = 0;
            end
            if (apply_pend) begin
                app_t a;
                apply_pend = 0;
                if (appq.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL apply: no expectation queued");
                end else begin
                    a = appq.pop_front();
                    chk("apply_ctl", {29'd0, bank_en, bank_set, bank_rst},
                        {29'd0, a.en, a.set, a.rst});
                    chk("apply_d", 32'(bank_d), 32'(a.d));
                end
            end else if (bank_en || bank_set || bank_rst || bank_d != 0) begin
                checks++; fails++;
                $display("FAIL stray_ctl: en=%b set=%b rst=%b d=%0h expected all 0",
                         bank_en, bank_set, bank_rst, bank_d);
            end
            if (bank_en || bank_set || bank_rst)
                chk("ctl_onehot", 32'($countones({bank_en, bank_set, bank_rst})), 32'd1);
            if (bus.gnt != 0) begin
                if (gntq.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL gnt: unexpected gnt=%b", bus.gnt);
                end else begin
                    int e;
                    e = gntq.pop_front();
                    chk("gnt", 32'(bus.gnt), 32'(1) << e);
                end
                if (chk_space && last_gnt_cyc >= 0) begin
                    chk("gnt_spacing", 32'(cyc - last_gnt_cyc), 32'd4);
                    chk("idle_gap", 32'(last_idle), 32'd1);
                end
                last_gnt_cyc = cyc;
                apply_pend = 1;
            end
            if (bus.ack != 0) begin
                if (ackq.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL ack: unexpected ack=%b rdata=%0h", bus.ack, bus.rdata);
                end else begin
                    ack_t k;
                    k = ackq.pop_front();
                    chk("ack", 32'(bus.ack), 32'(1) << k.idx);
                    chk("rdata", 32'(bus.rdata), 32'(k.rd));
                    chk("ack_latency", 32'(cyc - last_gnt_cyc), 32'd2);
                end
            end
        end
    end

    // mode 0: drop on ack; 1: drop on gnt; 2: also change req_data[0] on gnt
    task automatic run_ops(input int mode, input int bound);
        int n = 0;
        while (bus.req != 0 && n < bound) begin
            @(negedge clk);
            n++;
            if (mode == 2 && bus.gnt[0]) bus.req_data[7:0] = 8'h22;
            if (mode == 1) bus.req = bus.req & ~bus.gnt;
            bus.req = bus.req & ~bus.ack;
        end
        if (bus.req != 0) begin
            checks++; fails++;
            $display("FAIL run_timeout: req=%b still pending expected 0", bus.req);
            bus.req = '0;
        end
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((bus.busy || apply_pend || gntq.size() != 0 ||
                ackq.size() != 0) && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (n >= bound) begin
            checks++; fails++;
            $display("FAIL idle_timeout: busy=%b queues gnt=%0d ack=%0d expected idle",
                     bus.busy, gntq.size(), ackq.size());
        end
    endtask

    initial begin
        int ng;
        bus.req      = '0;
        bus.req_op   = '0;
        bus.req_data = '0;
        #1;
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_rdata", 32'(bus.rdata), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_bank", {21'd0, bank_en, bank_set, bank_rst, bank_d}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // All four READ continuously: order 0,1,2,3,0
        chk_space = 1;
        for (int i = 0; i < 5; i++) expect_op(i % 4, 0, 0, 0, 8'h00, 8'h00, 1);
        bus.req = 4'hF;
        ng = 0;
        for (int t = 0; t < 40 && ng < 5; t++) begin
            @(negedge clk);
            if (bus.gnt != 0) ng++;
        end
        bus.req = '0;
        if (ng < 5) begin
            checks++; fails++;
            $display("FAIL rr_grants: got %0d grants expected 5", ng);
        end
        wait_idle(30);
        chk_space = 0;

        // Single WRITE from requester 1
        bus.req_op[3:2]    = 2'b01;
        bus.req_data[15:8] = 8'hA5;
        expect_op(1, 1, 0, 0, 8'hA5, 8'hA5, 1);
        bus.req = 4'b0010;
        run_ops(0, 30);
        wait_idle(30);

        // SET then CLEAR from requester 2
        bus.req_op[5:4] = 2'b10;
        expect_op(2, 0, 1, 0, 8'h00, 8'hFF, 1);
        bus.req = 4'b0100;
        run_ops(0, 30);
        wait_idle(30);
        bus.req_op[5:4] = 2'b11;
        expect_op(2, 0, 0, 1, 8'h00, 8'h00, 1);
        bus.req = 4'b0100;
        run_ops(0, 30);
        wait_idle(30);

        // Committed WRITE from requester 3, req dropped after grant
        bus.req_op[7:6]     = 2'b01;
        bus.req_data[31:24] = 8'h3C;
        expect_op(3, 1, 0, 0, 8'h3C, 8'h3C, 1);
        bus.req = 4'b1000;
        run_ops(1, 30);
        wait_idle(30);
        bus.req_op[7:6] = 2'b00;
        expect_op(3, 0, 0, 0, 8'h00, 8'h3C, 1);
        bus.req = 4'b1000;
        run_ops(0, 30);
        wait_idle(30);

        // Data changed during GRANT must not reach the bank
        bus.req_op[1:0]  = 2'b01;
        bus.req_data[7:0] = 8'h11;
        expect_op(0, 1, 0, 0, 8'h11, 8'h11, 1);
        bus.req = 4'b0001;
        run_ops(2, 30);
        wait_idle(30);

        // Reset in the middle of APPLY of a WRITE
        bus.req_op[3:2]    = 2'b01;
        bus.req_data[15:8] = 8'h55;
        expect_op(1, 1, 0, 0, 8'h55, 8'h00, 0);
        bus.req = 4'b0010;
        ng = 0;
        for (int t = 0; t < 10 && ng == 0; t++) begin
            @(negedge clk);
            if (bus.gnt[1]) ng = 1;
        end
        chk("mid_gnt_seen", 32'(ng), 32'd1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_bank_en", 32'(bank_en), 32'd0);
        chk("mid_gnt", 32'(bus.gnt), 32'd0);
        chk("mid_ack", 32'(bus.ack), 32'd0);
        chk("mid_busy", 32'(bus.busy), 32'd0);
        bus.req = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_busy", 32'(bus.busy), 32'd0);
        chk("post_rst_bank", 32'(bank_q), 32'h11);

        // rr_ptr back at 0: requester 0 wins over 1
        bus.req_op[3:0] = 4'b0000;
        expect_op(0, 0, 0, 0, 8'h00, 8'h11, 1);
        expect_op(1, 0, 0, 0, 8'h00, 8'h11, 1);
        bus.req = 4'b0011;
        run_ops(0, 40);
        wait_idle(30);

        chk("queues_empty", 32'(gntq.size() + appq.size() + ackq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one bank of WIDTH dff cells among NUM_REQ requesters.
- Each requester issues one of READ, WRITE, SET or CLEAR. The block serialises these requests and drives the bank's common d/enable/set/reset controls for exactly one cycle per operation.
- It then returns an acknowledge, with read data, to the requester that won arbitration.
- It sits between the requester-side logic and the dff bank, whose d, enable, set and reset inputs are tied across all cells.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, number of dff cells in the bank (bits per access).

Ports:
- clk  input  1  single clock; rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester request level; held until that requester's ack.
- req_op  input  2*NUM_REQ  per-requester opcode, slice i = [2i+1:2i]: 00 READ, 01 WRITE, 10 SET, 11 CLEAR.
- req_data  input  WIDTH*NUM_REQ  per-requester write data, slice i = [WIDTH*(i+1)-1:WIDTH*i].
- gnt  output  NUM_REQ  one-hot grant pulse, one cycle.
- ack  output  NUM_REQ  one-hot completion pulse, one cycle.
- rdata  output  WIDTH  bank contents captured in DONE; valid in the cycle ack is high.
- busy  output  1  high whenever state is not IDLE.
- bank_d  output  WIDTH  data to bank d inputs.
- bank_en  output  1  bank enable.
- bank_set  output  1  bank set control.
- bank_rst  output  1  bank reset control.
- bank_q  input  WIDTH  bank q outputs.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, rr_ptr=0, latched winner/op/data cleared. All outputs (gnt, ack, rdata, busy, bank_d, bank_en, bank_set, bank_rst) are 0.
- Reset asserted mid-operation: the operation is abandoned and no ack is issued. Bank controls drop to 0 immediately, because they are asynchronously cleared.
- FSM states are IDLE, GRANT, APPLY, DONE.
- IDLE -> GRANT when |req is high.
  - Winner = first asserted req scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - At this edge: latch winner index, req_op[winner] and req_data[winner]; set gnt[winner]=1 (registered, visible during GRANT); set rr_ptr = (winner+1) mod NUM_REQ.
- GRANT -> APPLY unconditionally. Bank controls are registered and asserted during APPLY, exactly one cycle:
  - WRITE: bank_en=1, bank_d=latched data.
  - SET: bank_set=1.
  - CLEAR: bank_rst=1.
  - READ: no control asserted; bank_d=0.
- APPLY -> DONE unconditionally. During DONE, ack[winner]=1 and rdata=bank_q; the bank's update has already landed at the APPLY->DONE edge.
- DONE -> IDLE unconditionally.
- Latency: req sampled at edge E gives gnt high during cycle E..E+1, bank controls during E+1..E+2, and ack plus rdata during E+2..E+3.
- Throughput: one operation per 4 cycles. No back-to-back grant is possible, because one IDLE cycle always follows DONE.
- The operation is committed at grant. If req drops afterwards, the operation still completes and ack is still pulsed.
- Outside DONE, rdata holds its last value.
- Simultaneous requests are resolved by the round-robin scan only. No requester is starved: the worst-case wait is NUM_REQ operations.
- Requests arriving while busy are ignored until IDLE.
- req_op/req_data are sampled only at the IDLE->GRANT edge. Changes after that edge have no effect.
- At most one of bank_en/bank_set/bank_rst is ever high.
- rr_ptr wrap-around: when winner = NUM_REQ-1, rr_ptr returns to 0.

Decomposition:
- Shared package dff_bank_pkg holds:
  - opcode constants OP_READ=2'b00, OP_WRITE=2'b01, OP_SET=2'b10, OP_CLEAR=2'b11;
  - state encoding ST_IDLE, ST_GRANT, ST_APPLY, ST_DONE (2-bit).
- One natural sub-module: rr_picker. It is combinational; inputs are req and rr_ptr, and outputs are winner index and found.
- The FSM, latches and bank drive stay in the top module.

Test Plan:
- Reset check: assert reset mid-APPLY of a WRITE. Required: bank_en, gnt, ack and busy are 0 asynchronously; no ack follows; state returns to IDLE; next grant goes to requester 0.
- Single WRITE: req[1]=1, op=01, data=8'hA5. Required: gnt[1] on cycle 1, bank_en=1 and bank_d=A5 on cycle 2, ack[1] with rdata=A5 on cycle 3 (bank model is dff cells).
- SET then CLEAR from req[2]: SET gives bank_set pulse and rdata=FF at ack. The subsequent CLEAR gives bank_rst pulse and rdata=00.
- All four requesting READ continuously from reset: grant order is 0,1,2,3,0; each gnt is spaced 4 cycles apart; busy is low for exactly one cycle between operations.
- Committed operation: req[3] WRITE 8'h3C, deassert req after gnt. Required: write and ack[3] still occur; a subsequent READ returns 3C.
- Data sampling: change req_data[0] from 8'h11 to 8'h22 during GRANT. Required: bank_d=11 in APPLY.
